core_ctrl: RTL and testbench

//   Pipeline control stage directly downstream of core_ex. Owns the PC register, consumes

---
 rtl/core_ctrl.sv | 130 +++++++++++++
 tb/tb_core_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// core_ctrl: pipeline control stage downstream of core_ex.
// Owns the PC register and arbitrates jump/hold requests and the external bus stall,
// driving the fetch address, pipeline hold and if_id/id_ex flushes.
// Optional feature: define CORE_CTRL_JUMP_CNT_EN to add jump_cnt_out, a running
// count of accepted jumps.
module core_ctrl #(
    parameter logic [31:0] RST_ADDR     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_in,
    input  logic [31:0] jump_addr_in,
    input  logic        hold_flag_in,
    input  logic        hold_bus_in,
    output logic [31:0] pc_out,
    output logic        pc_valid_out,
    output logic        hold_out,
    output logic        flush_if_id_out,
    output logic        flush_id_ex_out,
`ifdef CORE_CTRL_JUMP_CNT_EN
    output logic [31:0] jump_cnt_out,
`endif
    output logic [1:0]  state_out
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Counter value after a jump: the jump cycle itself already counts as one flush cycle.
    localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [1:0] ST_AFTER_JUMP = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [31:0] pc;
    logic        pc_valid;
    logic        jump;
    logic        hold;
    logic [31:0] jump_target;
    logic [31:0] pc_next_seq;

    // Request decode: jump beats hold, and BOOT ignores both.
    always_comb begin
        jump        = 1'b0;
        hold        = 1'b0;
        jump_target = {jump_addr_in[31:2], jump_addr_in[1:0] & 2'b00};
        pc_next_seq = pc + 32'd4;
        if (state != ST_BOOT) begin
            jump = jump_flag_in;
            hold = (hold_flag_in | hold_bus_in) & ~jump_flag_in;
        end
    end

    // PC, valid flag, flush counter and FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_BOOT;
            cnt      <= 3'd0;
            pc       <= RST_ADDR;
            pc_valid <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= ST_RUN;
                    pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (jump) begin
                        pc    <= jump_target;
                        cnt   <= CNT_RELOAD;
                        state <= ST_AFTER_JUMP;
                    end else if (hold) begin
                        state <= ST_HOLD;
                    end else begin
                        pc <= pc_next_seq;
                    end
                end
                ST_FLUSH: begin
                    if (jump) begin
                        pc    <= jump_target;
                        cnt   <= CNT_RELOAD;
                        state <= ST_AFTER_JUMP;
                    end else if (!hold) begin
                        pc  <= pc_next_seq;
                        cnt <= cnt - 3'd1;
                        if (cnt <= 3'd1) begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    if (jump) begin
                        pc    <= jump_target;
                        cnt   <= CNT_RELOAD;
                        state <= ST_AFTER_JUMP;
                    end else if (!hold) begin
                        pc    <= pc_next_seq;
                        state <= ST_RUN;
                    end
                end
            endcase
        end
    end

`ifdef CORE_CTRL_JUMP_CNT_EN
    logic [31:0] jump_cnt;

    // Count every accepted jump; wraps silently at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jump_cnt <= 32'd0;
        end else if (jump) begin
            jump_cnt <= jump_cnt + 32'd1;
        end
    end

    assign jump_cnt_out = jump_cnt;
`endif

    assign pc_out          = pc;
    assign pc_valid_out    = pc_valid;
    assign state_out       = state;
    assign hold_out        = hold;
    assign flush_if_id_out = jump | (state == ST_FLUSH) | (state == ST_BOOT);
    assign flush_id_ex_out = jump | (state == ST_BOOT);

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed tests for core_ctrl with default parameters
// (RST_ADDR=0, FLUSH_CYCLES=2). Define CORE_CTRL_JUMP_CNT_EN to also test jump_cnt_out.
module tb_core_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_flag_in;
    logic [31:0] jump_addr_in;
    logic        hold_flag_in;
    logic        hold_bus_in;
    logic [31:0] pc_out;
    logic        pc_valid_out;
    logic        hold_out;
    logic        flush_if_id_out;
    logic        flush_id_ex_out;
    logic [1:0]  state_out;
`ifdef CORE_CTRL_JUMP_CNT_EN
    logic [31:0] jump_cnt_out;
`endif

    int checks;
    int failures;

    core_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .jump_flag_in   (jump_flag_in),
        .jump_addr_in   (jump_addr_in),
        .hold_flag_in   (hold_flag_in),
        .hold_bus_in    (hold_bus_in),
        .pc_out         (pc_out),
        .pc_valid_out   (pc_valid_out),
        .hold_out       (hold_out),
        .flush_if_id_out(flush_if_id_out),
        .flush_id_ex_out(flush_id_ex_out),
`ifdef CORE_CTRL_JUMP_CNT_EN
        .jump_cnt_out   (jump_cnt_out),
`endif
        .state_out      (state_out)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then step through BOOT so the DUT sits in RUN with pc=0.
    task automatic do_reset();
        jump_flag_in = 1'b0;
        jump_addr_in = 32'd0;
        hold_flag_in = 1'b0;
        hold_bus_in  = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        jump_flag_in = 1'b0;
        jump_addr_in = 32'd0;
        hold_flag_in = 1'b0;
        hold_bus_in  = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({pc_out, pc_valid_out, hold_out, flush_if_id_out, flush_id_ex_out, state_out} !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0}) begin
            failures++;
            $display("[TB] FAIL reset_values: pc=%h valid=%b hold=%b fif=%b fex=%b st=%0d, want pc=0 valid=0 hold=0 fif=1 fex=1 st=0",
                     pc_out, pc_valid_out, hold_out, flush_if_id_out, flush_id_ex_out, state_out);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (state_out !== 2'd0 || flush_if_id_out !== 1'b1 || pc_valid_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL boot_cycle: st=%0d fif=%b valid=%b, want st=0 fif=1 valid=0", state_out, flush_if_id_out, pc_valid_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc_out !== 32'(i * 4) || pc_valid_out !== 1'b1 || state_out !== 2'd1) begin
                failures++;
                $display("[TB] FAIL run_seq%0d: pc=%h valid=%b st=%0d, want pc=%h valid=1 st=1", i, pc_out, pc_valid_out, state_out, 32'(i * 4));
            end
        end
    endtask

    task automatic test_boot_ignore();
        jump_flag_in = 1'b0;
        hold_flag_in = 1'b0;
        hold_bus_in  = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        jump_flag_in = 1'b1;
        jump_addr_in = 32'h500;
        hold_flag_in = 1'b1;
        #1;
        checks++;
        if (hold_out !== 1'b0 || flush_id_ex_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL boot_ignore_comb: hold=%b fex=%b, want hold=0 fex=1", hold_out, flush_id_ex_out);
        end
        tick();
        jump_flag_in = 1'b0;
        hold_flag_in = 1'b0;
        checks++;
        if (pc_out !== 32'h0 || state_out !== 2'd1) begin
            failures++;
            $display("[TB] FAIL boot_ignore_pc: pc=%h st=%0d, want pc=0 st=1", pc_out, state_out);
        end
    endtask

    task automatic test_jump();
        do_reset();
        repeat (4) tick();
        jump_flag_in = 1'b1;
        jump_addr_in = 32'h103;
        #1;
        checks++;
        if (pc_out !== 32'h10 || flush_if_id_out !== 1'b1 || flush_id_ex_out !== 1'b1 || hold_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jump_cycle: pc=%h fif=%b fex=%b hold=%b, want pc=10 fif=1 fex=1 hold=0",
                     pc_out, flush_if_id_out, flush_id_ex_out, hold_out);
        end
        tick();
        jump_flag_in = 1'b0;
        #1;
        checks++;
        if (pc_out !== 32'h100 || state_out !== 2'd2 || flush_if_id_out !== 1'b1 || flush_id_ex_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jump_target: pc=%h st=%0d fif=%b fex=%b, want pc=100 st=2 fif=1 fex=0",
                     pc_out, state_out, flush_if_id_out, flush_id_ex_out);
        end
        tick();
        checks++;
        if (pc_out !== 32'h104 || state_out !== 2'd1 || flush_if_id_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jump_resume: pc=%h st=%0d fif=%b, want pc=104 st=1 fif=0", pc_out, state_out, flush_if_id_out);
        end
    endtask

    task automatic test_hold();
        do_reset();
        repeat (8) tick();
        hold_bus_in = 1'b1;
        #1;
        checks++;
        if (hold_out !== 1'b1 || flush_if_id_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_comb: hold=%b fif=%b, want hold=1 fif=0", hold_out, flush_if_id_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) begin
                checks++;
                if (pc_out !== 32'h20 || state_out !== 2'd3 || hold_out !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL hold_frozen%0d: pc=%h st=%0d hold=%b, want pc=20 st=3 hold=1", i, pc_out, state_out, hold_out);
                end
            end
        end
        hold_bus_in = 1'b0;
        #1;
        checks++;
        if (pc_out !== 32'h20 || state_out !== 2'd3 || hold_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_release: pc=%h st=%0d hold=%b, want pc=20 st=3 hold=0", pc_out, state_out, hold_out);
        end
        tick();
        checks++;
        if (pc_out !== 32'h24 || state_out !== 2'd1) begin
            failures++;
            $display("[TB] FAIL hold_resume: pc=%h st=%0d, want pc=24 st=1", pc_out, state_out);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        jump_flag_in = 1'b1;
        jump_addr_in = 32'h200;
        hold_flag_in = 1'b1;
        #1;
        checks++;
        if (hold_out !== 1'b0 || flush_id_ex_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL jump_beats_hold: hold=%b fex=%b, want hold=0 fex=1", hold_out, flush_id_ex_out);
        end
        tick();
        hold_flag_in = 1'b0;
        jump_addr_in = 32'h302;
        checks++;
        if (pc_out !== 32'h200 || state_out !== 2'd2) begin
            failures++;
            $display("[TB] FAIL simul_target: pc=%h st=%0d, want pc=200 st=2", pc_out, state_out);
        end
        tick();
        jump_flag_in = 1'b0;
        checks++;
        if (pc_out !== 32'h300 || state_out !== 2'd2) begin
            failures++;
            $display("[TB] FAIL rejump_flush: pc=%h st=%0d, want pc=300 st=2", pc_out, state_out);
        end
        tick();
        checks++;
        if (pc_out !== 32'h304 || state_out !== 2'd1) begin
            failures++;
            $display("[TB] FAIL rejump_resume: pc=%h st=%0d, want pc=304 st=1", pc_out, state_out);
        end
    endtask

    task automatic test_wrap_and_flush_hold();
        do_reset();
        jump_flag_in = 1'b1;
        jump_addr_in = 32'hFFFF_FFF8;
        tick();
        jump_flag_in = 1'b0;
        tick();
        checks++;
        if (pc_out !== 32'hFFFF_FFFC || state_out !== 2'd1) begin
            failures++;
            $display("[TB] FAIL pre_wrap: pc=%h st=%0d, want pc=fffffffc st=1", pc_out, state_out);
        end
        tick();
        checks++;
        if (pc_out !== 32'h0 || state_out !== 2'd1) begin
            failures++;
            $display("[TB] FAIL wrap: pc=%h st=%0d, want pc=0 st=1", pc_out, state_out);
        end
        jump_flag_in = 1'b1;
        jump_addr_in = 32'h40;
        tick();
        jump_flag_in = 1'b0;
        hold_flag_in = 1'b1;
        #1;
        checks++;
        if (hold_out !== 1'b1 || flush_if_id_out !== 1'b1 || flush_id_ex_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_hold_comb: hold=%b fif=%b fex=%b, want hold=1 fif=1 fex=0", hold_out, flush_if_id_out, flush_id_ex_out);
        end
        repeat (2) tick();
        checks++;
        if (pc_out !== 32'h40 || state_out !== 2'd2) begin
            failures++;
            $display("[TB] FAIL flush_hold_frozen: pc=%h st=%0d, want pc=40 st=2", pc_out, state_out);
        end
        hold_flag_in = 1'b0;
        tick();
        checks++;
        if (pc_out !== 32'h44 || state_out !== 2'd1) begin
            failures++;
            $display("[TB] FAIL flush_hold_resume: pc=%h st=%0d, want pc=44 st=1", pc_out, state_out);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        repeat (3) tick();
        hold_bus_in = 1'b1;
        tick();
        checks++;
        if (state_out !== 2'd3 || pc_out !== 32'hC) begin
            failures++;
            $display("[TB] FAIL pre_reset_hold: pc=%h st=%0d, want pc=c st=3", pc_out, state_out);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({pc_out, pc_valid_out, hold_out, flush_if_id_out, flush_id_ex_out, state_out} !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0}) begin
            failures++;
            $display("[TB] FAIL async_reset_hold: pc=%h valid=%b hold=%b fif=%b fex=%b st=%0d, want pc=0 valid=0 hold=0 fif=1 fex=1 st=0",
                     pc_out, pc_valid_out, hold_out, flush_if_id_out, flush_id_ex_out, state_out);
        end
        hold_bus_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (pc_out !== 32'h4 || state_out !== 2'd1) begin
            failures++;
            $display("[TB] FAIL post_reset_run: pc=%h st=%0d, want pc=4 st=1", pc_out, state_out);
        end
    endtask

`ifdef CORE_CTRL_JUMP_CNT_EN
    task automatic test_jump_cnt();
        do_reset();
        checks++;
        if (jump_cnt_out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL jump_cnt_init: got %0d, want 0", jump_cnt_out);
        end
        jump_flag_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            jump_addr_in = 32'h1000 + 32'(i * 16);
            tick();
        end
        jump_flag_in = 1'b0;
        checks++;
        if (jump_cnt_out !== 32'd3 || pc_out !== 32'h1020) begin
            failures++;
            $display("[TB] FAIL jump_cnt_three: cnt=%0d pc=%h, want cnt=3 pc=1020", jump_cnt_out, pc_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (jump_cnt_out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL jump_cnt_reset: got %0d, want 0", jump_cnt_out);
        end
        rst = 1'b1;
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        jump_flag_in = 1'b0;
        jump_addr_in = 32'd0;
        hold_flag_in = 1'b0;
        hold_bus_in  = 1'b0;
        #2;
        test_reset();
        test_boot_ignore();
        test_jump();
        test_hold();
        test_simultaneous();
        test_wrap_and_flush_hold();
        test_reset_mid_hold();
`ifdef CORE_CTRL_JUMP_CNT_EN
        test_jump_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
